if_id_pipeline_register: RTL and testbench
==========================================

Name: if_id_pipeline_register

Overview:
- Fetch-to-decode pipeline register that sits directly downstream of the PC/nPC register and PC+4 adder.
- Each cycle it captures the fetched instruction word together with its PC and nPC, and presents them to the decode (ID) stage.
- Implements SPARC delay-slot semantics: after ID reports a control-transfer instruction (CTI), it marks the next fetched instruction as the delay slot and annuls it when required.
- Also handles stalls (le=0), flushes, and instruction-memory not-ready cycles; it keeps a saturating count of annulled delay slots.

Parameters:
- WIDTH, 32, width of the instruction, PC and nPC datapaths.
- NOP_INSTR, 32'h0100_0000, bubble encoding (sethi 0,%g0) loaded into instr_out whenever no valid instruction is present.
- CNT_W, 16, width of the annul statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- le  input  1  load enable; 0 = stall, all state held.
- flush  input  1  synchronous squash of the IF/ID contents.
- fetch_valid  input  1  instruction memory has a valid word this cycle.
- instr_in  input  WIDTH  fetched instruction word.
- pc_in  input  WIDTH  PC of the fetched instruction (PC register output).
- npc_in  input  WIDTH  nPC of the fetched instruction (adder output).
- cti_valid  input  1  ID decodes a CTI in the instruction currently held in instr_out.
- cti_taken  input  1  the CTI in ID is taken.
- cti_annul  input  1  annul bit (a) of the CTI in ID.
- cti_uncond  input  1  CTI is ba/fba (unconditional branch always).
- instr_out  output  WIDTH  instruction presented to ID.
- pc_out  output  WIDTH  PC presented to ID.
- npc_out  output  WIDTH  nPC presented to ID.
- valid_out  output  1  instr_out is a real, non-annulled instruction.
- delay_slot_out  output  1  instr_out is a delay-slot instruction; stays 1 even when annulled.
- annul_count  output  CNT_W  number of annulled delay slots, saturating.

Behaviour:
- Reset (clr=0, asynchronous, overrides everything):
  - instr_out=NOP_INSTR; pc_out=0; npc_out=0.
  - valid_out=0; delay_slot_out=0; annul_count=0.
  - FSM goes to NORMAL.
- Priority on each rising edge: flush > le=0 > normal update.
- flush=1:
  - instr_out=NOP_INSTR, valid_out=0, delay_slot_out=0.
  - pc_out/npc_out held; FSM goes to NORMAL.
  - annul_count unchanged.
  - flush wins over le=0.
- le=0 (and flush=0): every register, including FSM state, is held.
- Normal update (le=1, flush=0):
  - pc_out<=pc_in and npc_out<=npc_in, always.
  - Latency: one cycle from the IF inputs to the outputs.
- annul is a combinational term: cti_annul & (~cti_taken | cti_uncond).
- cti_event = cti_valid & valid_out & (state==NORMAL). cti_valid is ignored when valid_out=0 or the FSM is in WAIT_SLOT.
- FSM state NORMAL:
  - No cti_event: instr_out = fetch_valid ? instr_in : NOP_INSTR; valid_out=fetch_valid; delay_slot_out=0.
  - cti_event & fetch_valid: instr_out=instr_in; delay_slot_out=1; valid_out=~annul. If annul, annul_count increments.
  - cti_event & ~fetch_valid: load bubble (NOP_INSTR, valid_out=0, delay_slot_out=0); annul_pending<=annul; go to WAIT_SLOT.
- FSM state WAIT_SLOT:
  - fetch_valid=1: instr_out=instr_in; delay_slot_out=1; valid_out=~annul_pending. If annul_pending, annul_count increments. Go to NORMAL.
  - fetch_valid=0: load bubble again and stay in WAIT_SLOT. Any number of not-ready cycles is allowed.
- annul_count saturates at all-ones and never wraps.
- Reset or flush while in WAIT_SLOT discards the pending delay slot; annul_pending is cleared.
- Back-to-back CTIs: a CTI that sits in a delay slot (delay_slot_out=1, valid_out=1) is itself a legal cti_event for the next instruction.
- An annulled delay slot (valid_out=0) can never produce a cti_event.

Test Plan:
- Reset/stream:
  - clr=0 gives outputs NOP_INSTR/0/0/0/0/0.
  - Release clr; drive instr_in=32'hA, pc_in=0, npc_in=4, fetch_valid=1, le=1.
  - Required: after one edge instr_out=32'hA, pc_out=0, npc_out=4, valid_out=1, delay_slot_out=0.
- Stall/flush:
  - le=0 for 3 edges while the inputs change: outputs unchanged.
  - flush=1 together with le=0: next edge gives instr_out=32'h0100_0000, valid_out=0, pc_out held.
- Annulled untaken branch:
  - valid CTI in ID; cti_valid=1, cti_annul=1, cti_taken=0, instr_in=32'hB.
  - Required: next edge instr_out=32'hB, delay_slot_out=1, valid_out=0, annul_count=1.
- Taken branches:
  - cti_taken=1, cti_annul=1, cti_uncond=0: slot valid_out=1, counter unchanged.
  - Same with cti_uncond=1 (ba,a): valid_out=0, counter +1.
- Memory not ready:
  - cti_event with fetch_valid=0 for 2 cycles, cti_annul=1, cti_taken=0.
  - Required: 2 bubbles (valid_out=0, delay_slot_out=0); third edge with fetch_valid=1 loads the slot with delay_slot_out=1, valid_out=0.
  - Repeat with clr pulsed mid-wait: after recovery, the next instruction has delay_slot_out=0.
- Counter saturation:
  - Preload via 65535 annulled slots (or a CNT_W=2 build with 3 annulled slots).
  - One more annulled slot: count stays 16'hFFFF (2'b11).

Source files
------------

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: latches instruction, PC and nPC for decode, applies SPARC
// delay-slot marking/annulment, and keeps a saturating count of annulled slots.
module if_id_pipeline_register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0100_0000),
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             le,
    input  logic             flush,
    input  logic             fetch_valid,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] npc_in,
    input  logic             cti_valid,
    input  logic             cti_taken,
    input  logic             cti_annul,
    input  logic             cti_uncond,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic             valid_out,
    output logic             delay_slot_out,
    output logic [CNT_W-1:0] annul_count
);

    typedef enum logic {
        NORMAL    = 1'b0,
        WAIT_SLOT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             annul_pending;
    logic             pend_next;
    logic [WIDTH-1:0] instr_next;
    logic             valid_next;
    logic             ds_next;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_next;
    logic             annul;
    logic             cti_event;

    // An untaken annulling branch, or ba,a, squashes its delay slot.
    assign annul     = cti_annul & (~cti_taken | cti_uncond);
    assign cti_event = cti_valid & valid_out & (state == NORMAL);

    always_comb begin
        state_next = state;
        pend_next  = annul_pending;
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
        ds_next    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            NORMAL: begin
                if (cti_event) begin
                    if (fetch_valid) begin
                        instr_next = instr_in;
                        ds_next    = 1'b1;
                        valid_next = ~annul;
                        cnt_inc    = annul;
                    end else begin
                        // Slot not fetched yet: remember its fate until it arrives.
                        pend_next  = annul;
                        state_next = WAIT_SLOT;
                    end
                end else begin
                    if (fetch_valid) instr_next = instr_in;
                    valid_next = fetch_valid;
                end
            end
            WAIT_SLOT: begin
                if (fetch_valid) begin
                    instr_next = instr_in;
                    ds_next    = 1'b1;
                    valid_next = ~annul_pending;
                    cnt_inc    = annul_pending;
                    pend_next  = 1'b0;
                    state_next = NORMAL;
                end
            end
            default: begin
                state_next = NORMAL;
                pend_next  = 1'b0;
            end
        endcase
    end

    assign cnt_next = (cnt_inc && (annul_count != {CNT_W{1'b1}}))
                      ? annul_count + CNT_W'(1) : annul_count;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= NORMAL;
            annul_pending  <= 1'b0;
            instr_out      <= NOP_INSTR;
            pc_out         <= '0;
            npc_out        <= '0;
            valid_out      <= 1'b0;
            delay_slot_out <= 1'b0;
            annul_count    <= '0;
        end else if (flush) begin
            state          <= NORMAL;
            annul_pending  <= 1'b0;
            instr_out      <= NOP_INSTR;
            valid_out      <= 1'b0;
            delay_slot_out <= 1'b0;
        end else if (le) begin
            state          <= state_next;
            annul_pending  <= pend_next;
            instr_out      <= instr_next;
            pc_out         <= pc_in;
            npc_out        <= npc_in;
            valid_out      <= valid_next;
            delay_slot_out <= ds_next;
            annul_count    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Directed bench for if_id_pipeline_register: driver pushes hand-computed expectations,
// a monitor pops and compares them after every rising edge.
module tb_if_id_pipeline_register;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0100_0000;
    localparam int          EW  = 3 * W + 2 + 16 + 2;

    logic          clk;
    logic          clr;
    logic          le;
    logic          flush;
    logic          fetch_valid;
    logic [W-1:0]  instr_in;
    logic [W-1:0]  pc_in;
    logic [W-1:0]  npc_in;
    logic          cti_valid;
    logic          cti_taken;
    logic          cti_annul;
    logic          cti_uncond;
    logic [W-1:0]  instr_out;
    logic [W-1:0]  pc_out;
    logic [W-1:0]  npc_out;
    logic          valid_out;
    logic          delay_slot_out;
    logic [15:0]   annul_count;
    logic [W-1:0]  s_instr_out;
    logic [W-1:0]  s_pc_out;
    logic [W-1:0]  s_npc_out;
    logic          s_valid_out;
    logic          s_delay_slot_out;
    logic [1:0]    s_annul_count;

    logic [EW-1:0] exp_q[$];
    int            n_tests;
    int            n_fail;

    if_id_pipeline_register #(.WIDTH(W), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .le(le), .flush(flush), .fetch_valid(fetch_valid),
        .instr_in(instr_in), .pc_in(pc_in), .npc_in(npc_in),
        .cti_valid(cti_valid), .cti_taken(cti_taken), .cti_annul(cti_annul),
        .cti_uncond(cti_uncond),
        .instr_out(instr_out), .pc_out(pc_out), .npc_out(npc_out),
        .valid_out(valid_out), .delay_slot_out(delay_slot_out), .annul_count(annul_count)
    );

    // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
    if_id_pipeline_register #(.WIDTH(W), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
        .clk(clk), .clr(clr), .le(le), .flush(flush), .fetch_valid(fetch_valid),
        .instr_in(instr_in), .pc_in(pc_in), .npc_in(npc_in),
        .cti_valid(cti_valid), .cti_taken(cti_taken), .cti_annul(cti_annul),
        .cti_uncond(cti_uncond),
        .instr_out(s_instr_out), .pc_out(s_pc_out), .npc_out(s_npc_out),
        .valid_out(s_valid_out), .delay_slot_out(s_delay_slot_out),
        .annul_count(s_annul_count)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clr = 1'b0; le = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        instr_in = '0; pc_in = '0; npc_in = '0;
        cti_valid = 1'b0; cti_taken = 1'b0; cti_annul = 1'b0; cti_uncond = 1'b0;
    end

    // Driver: apply one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic c_clr, input logic c_le, input logic c_flush,
                        input logic c_fv, input logic [W-1:0] c_instr,
                        input logic [W-1:0] c_pc, input logic [W-1:0] c_npc,
                        input logic c_cv, input logic c_ct, input logic c_ca,
                        input logic c_cu,
                        input logic [W-1:0] e_instr, input logic [W-1:0] e_pc,
                        input logic [W-1:0] e_npc, input logic e_valid,
                        input logic e_ds, input int e_cnt);
        logic [1:0] e_cnt2;
        @(negedge clk);
        clr = c_clr; le = c_le; flush = c_flush; fetch_valid = c_fv;
        instr_in = c_instr; pc_in = c_pc; npc_in = c_npc;
        cti_valid = c_cv; cti_taken = c_ct; cti_annul = c_ca; cti_uncond = c_cu;
        e_cnt2 = (e_cnt > 3) ? 2'd3 : 2'(e_cnt);
        exp_q.push_back({e_instr, e_pc, e_npc, e_valid, e_ds, 16'(e_cnt), e_cnt2});
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {instr_out, pc_out, npc_out, valid_out, delay_slot_out, annul_count,
                 s_annul_count};
            n_tests++;
            if (a !== e || s_instr_out !== instr_out || s_valid_out !== valid_out ||
                s_delay_slot_out !== delay_slot_out || s_pc_out !== pc_out ||
                s_npc_out !== npc_out) begin
                n_fail++;
                $display("FAIL check%0d t=%0t: got instr=%h pc=%h npc=%h v=%b ds=%b cnt=%0d cnt2=%0d | want instr=%h pc=%h npc=%h v=%b ds=%b cnt=%0d cnt2=%0d",
                         n_tests, $time, a[EW-1-:W], a[EW-W-1-:W], a[EW-2*W-1-:W],
                         a[19], a[18], a[17:2], a[1:0],
                         e[EW-1-:W], e[EW-W-1-:W], e[EW-2*W-1-:W],
                         e[19], e[18], e[17:2], e[1:0]);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //   clr le fl fv instr     pc        npc       cv ct ca cu | instr  pc     npc    v  ds cnt
        step(0, 0, 0, 0, 32'h0,    32'h0,    32'h0,    0, 0, 0, 0,  NOP,   32'h0, 32'h0, 0, 0, 0);
        step(1, 1, 0, 1, 32'hA,    32'h0,    32'h4,    0, 0, 0, 0,  32'hA, 32'h0, 32'h4, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 1, 32'h99 + 32'(i), 32'h8, 32'hC, 1, 0, 1, 0,
                 32'hA, 32'h0, 32'h4, 1, 0, 0);
        step(1, 0, 1, 1, 32'h77,   32'h10,   32'h14,   0, 0, 0, 0,  NOP,   32'h0, 32'h4, 0, 0, 0);
        // CTI in ID, then annulled untaken delay slot
        step(1, 1, 0, 1, 32'h20,   32'h8,    32'hC,    0, 0, 0, 0,  32'h20, 32'h8, 32'hC, 1, 0, 0);
        step(1, 1, 0, 1, 32'hB,    32'hC,    32'h10,   1, 0, 1, 0,  32'hB, 32'hC, 32'h10, 0, 1, 1);
        // annulled slot in ID must not trigger a CTI event
        step(1, 1, 0, 1, 32'h30,   32'h10,   32'h14,   1, 1, 0, 0,  32'h30, 32'h10, 32'h14, 1, 0, 1);
        // taken conditional with annul bit: slot executes
        step(1, 1, 0, 1, 32'h34,   32'h14,   32'h18,   1, 1, 1, 0,  32'h34, 32'h14, 32'h18, 1, 1, 1);
        // CTI sitting in a delay slot: ba,a annuls the next one
        step(1, 1, 0, 1, 32'h38,   32'h18,   32'h1C,   1, 1, 1, 1,  32'h38, 32'h18, 32'h1C, 0, 1, 2);
        step(1, 1, 0, 1, 32'h40,   32'h40,   32'h44,   0, 0, 0, 0,  32'h40, 32'h40, 32'h44, 1, 0, 2);
        // memory not ready for two cycles after an annulling CTI
        step(1, 1, 0, 0, 32'h44,   32'h44,   32'h48,   1, 0, 1, 0,  NOP,   32'h44, 32'h48, 0, 0, 2);
        step(1, 1, 0, 0, 32'h44,   32'h44,   32'h48,   1, 0, 0, 0,  NOP,   32'h44, 32'h48, 0, 0, 2);
        step(1, 1, 0, 1, 32'h44,   32'h44,   32'h48,   0, 0, 0, 0,  32'h44, 32'h44, 32'h48, 0, 1, 3);
        step(1, 1, 0, 1, 32'h50,   32'h50,   32'h54,   0, 0, 0, 0,  32'h50, 32'h50, 32'h54, 1, 0, 3);
        // reset pulsed while waiting for the slot
        step(1, 1, 0, 0, 32'h54,   32'h54,   32'h58,   1, 0, 1, 0,  NOP,   32'h54, 32'h58, 0, 0, 3);
        step(0, 1, 0, 0, 32'h54,   32'h54,   32'h58,   0, 0, 0, 0,  NOP,   32'h0, 32'h0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h60,   32'h60,   32'h64,   0, 0, 0, 0,  32'h60, 32'h60, 32'h64, 1, 0, 0);
        // four annulled slots: narrow counter saturates at 3
        step(1, 1, 0, 1, 32'h61,   32'h64,   32'h68,   1, 0, 1, 0,  32'h61, 32'h64, 32'h68, 0, 1, 1);
        step(1, 1, 0, 1, 32'h62,   32'h68,   32'h6C,   0, 0, 0, 0,  32'h62, 32'h68, 32'h6C, 1, 0, 1);
        step(1, 1, 0, 1, 32'h63,   32'h6C,   32'h70,   1, 0, 1, 0,  32'h63, 32'h6C, 32'h70, 0, 1, 2);
        step(1, 1, 0, 1, 32'h64,   32'h70,   32'h74,   0, 0, 0, 0,  32'h64, 32'h70, 32'h74, 1, 0, 2);
        step(1, 1, 0, 1, 32'h65,   32'h74,   32'h78,   1, 0, 1, 0,  32'h65, 32'h74, 32'h78, 0, 1, 3);
        step(1, 1, 0, 1, 32'h66,   32'h78,   32'h7C,   0, 0, 0, 0,  32'h66, 32'h78, 32'h7C, 1, 0, 3);
        step(1, 1, 0, 1, 32'h67,   32'h7C,   32'h80,   1, 0, 1, 0,  32'h67, 32'h7C, 32'h80, 0, 1, 4);
        // flush while waiting discards the pending slot
        step(1, 1, 0, 1, 32'h68,   32'h80,   32'h84,   0, 0, 0, 0,  32'h68, 32'h80, 32'h84, 1, 0, 4);
        step(1, 1, 0, 0, 32'h6C,   32'h84,   32'h88,   1, 0, 1, 0,  NOP,   32'h84, 32'h88, 0, 0, 4);
        step(1, 1, 1, 0, 32'h6C,   32'h88,   32'h8C,   0, 0, 0, 0,  NOP,   32'h84, 32'h88, 0, 0, 4);
        step(1, 1, 0, 1, 32'h6C,   32'h88,   32'h8C,   0, 0, 0, 0,  32'h6C, 32'h88, 32'h8C, 1, 0, 4);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
